// File: rtl/jag_lightgun_sched.sv
// ---------------------------------------------------------------------------
// jag_lightgun_sched
//
// Shares the single Jaguar light-pen capture resource between two lightgun
// front-ends. Requests come from synchronized trigger edges, or from the
// present mask every cycle in auto-fire mode. At each vsync rise one
// requesting gun is armed for hit detection; the first hit latches the beam
// position. MISS_FRAMES frames without a hit yields a miss result. Either
// result is held until acknowledged, or dropped after HOLD_FRAMES frames.
//
// Handshake: a result is offered with lp_valid=1 (lp_miss qualifies it)
// and stays stable until the consumer pulses rd_ack for one cycle while
// lp_valid is high; lp_valid drops on the following cycle. rd_ack with
// lp_valid low is ignored.
//
// Ports:
//   clk, reset          xvclk and synchronous active-high reset
//   enable              block enable; low forces IDLE and clears requests
//   auto_fire           1 = present guns request every frame, triggers ignored
//   gun_present[1:0]    per-gun enable mask
//   trig[1:0]           raw asynchronous trigger buttons
//   hit[1:0]            per-gun hit-window strobe (clk domain)
//   vsync               active-high vertical sync
//   cycle[11:0]         beam x in video clocks
//   scanline[9:0]       beam y
//   rd_ack              one-cycle consumer acknowledge
//   gun_en[1:0]         one-hot hit-detect enable to the armed gun
//   lp_valid, lp_miss   result available / result is a miss
//   lp_port             gun index of the result
//   lp_x[11:0], lp_y[9:0] captured beam position
//   busy                state is not IDLE
//   dbg_state[1:0]      raw FSM state (0 IDLE, 1 SCAN, 2 HOLD)
// ---------------------------------------------------------------------------
module jag_lightgun_sched #(
  parameter int MISS_FRAMES = 2,
  parameter int HOLD_FRAMES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        auto_fire,
  input  logic [1:0]  gun_present,
  input  logic [1:0]  trig,
  input  logic [1:0]  hit,
  input  logic        vsync,
  input  logic [11:0] cycle,
  input  logic [9:0]  scanline,
  input  logic        rd_ack,
  output logic [1:0]  gun_en,
  output logic        lp_valid,
  output logic        lp_miss,
  output logic        lp_port,
  output logic [11:0] lp_x,
  output logic [9:0]  lp_y,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  localparam int MW = $clog2(MISS_FRAMES) + 1;
  localparam int HW = $clog2(HOLD_FRAMES) + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t        r_state;
  logic [1:0]    r_trig_s1;
  logic [1:0]    r_trig_s2;
  logic [1:0]    r_trig_d;
  logic          r_vsync_d;
  logic [1:0]    r_req;
  logic          r_last;
  logic          r_sel;
  logic [MW-1:0] r_miss_cnt;
  logic [HW-1:0] r_hold_cnt;
  logic [1:0]    r_gun_en;
  logic          r_lp_valid;
  logic          r_lp_miss;
  logic          r_lp_port;
  logic [11:0]   r_lp_x;
  logic [9:0]    r_lp_y;

  logic [1:0]    w_trig_rise;
  logic          w_vsync_rise;
  logic [MW-1:0] w_miss_inc;
  logic [HW-1:0] w_hold_inc;

  state_t        w_state_nxt;
  logic          w_sel_nxt;
  logic          w_last_nxt;
  logic [MW-1:0] w_miss_cnt_nxt;
  logic [HW-1:0] w_hold_cnt_nxt;
  logic [1:0]    w_gun_en_nxt;
  logic          w_lp_valid_nxt;
  logic          w_lp_miss_nxt;
  logic          w_lp_port_nxt;
  logic [11:0]   w_lp_x_nxt;
  logic [9:0]    w_lp_y_nxt;
  logic [1:0]    w_req_clr;
  logic [1:0]    w_req_nxt;
  logic          w_tie_sel;

  assign w_trig_rise  = r_trig_s2 & ~r_trig_d;
  assign w_vsync_rise = vsync & ~r_vsync_d;

  // Saturating increments: the counters never wrap past their terminal value.
  assign w_miss_inc = (r_miss_cnt == MW'(MISS_FRAMES)) ? r_miss_cnt : r_miss_cnt + MW'(1);
  assign w_hold_inc = (r_hold_cnt == HW'(HOLD_FRAMES)) ? r_hold_cnt : r_hold_cnt + HW'(1);

  // With both guns requesting, serve the one not served last.
  assign w_tie_sel = (r_req == 2'b11) ? ~r_last : r_req[1];

  // Next-state and registered-output logic
  always_comb begin
    w_state_nxt    = r_state;
    w_sel_nxt      = r_sel;
    w_last_nxt     = r_last;
    w_miss_cnt_nxt = r_miss_cnt;
    w_hold_cnt_nxt = r_hold_cnt;
    w_gun_en_nxt   = r_gun_en;
    w_lp_valid_nxt = r_lp_valid;
    w_lp_miss_nxt  = r_lp_miss;
    w_lp_port_nxt  = r_lp_port;
    w_lp_x_nxt     = r_lp_x;
    w_lp_y_nxt     = r_lp_y;
    w_req_clr      = 2'b00;

    if (!enable) begin
      w_state_nxt    = ST_IDLE;
      w_gun_en_nxt   = 2'b00;
      w_lp_valid_nxt = 1'b0;
      w_lp_miss_nxt  = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_vsync_rise && (r_req != 2'b00)) begin
            w_sel_nxt      = w_tie_sel;
            w_gun_en_nxt   = w_tie_sel ? 2'b10 : 2'b01;
            w_miss_cnt_nxt = '0;
            w_state_nxt    = ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (!gun_present[r_sel]) begin
            // Armed gun unplugged: abandon the scan without a result.
            w_gun_en_nxt       = 2'b00;
            w_req_clr[r_sel]   = 1'b1;
            w_state_nxt        = ST_IDLE;
          end else if (hit[r_sel]) begin
            // Hit takes priority over a coincident vsync rise.
            w_lp_x_nxt         = cycle;
            w_lp_y_nxt         = scanline;
            w_lp_port_nxt      = r_sel;
            w_lp_miss_nxt      = 1'b0;
            w_lp_valid_nxt     = 1'b1;
            w_gun_en_nxt       = 2'b00;
            w_req_clr[r_sel]   = 1'b1;
            w_last_nxt         = r_sel;
            w_hold_cnt_nxt     = '0;
            w_state_nxt        = ST_HOLD;
          end else if (w_vsync_rise) begin
            w_miss_cnt_nxt = w_miss_inc;
            if (w_miss_inc == MW'(MISS_FRAMES)) begin
              w_lp_miss_nxt    = 1'b1;
              w_lp_valid_nxt   = 1'b1;
              w_lp_x_nxt       = '0;
              w_lp_y_nxt       = '0;
              w_lp_port_nxt    = r_sel;
              w_req_clr[r_sel] = 1'b1;
              w_last_nxt       = r_sel;
              w_gun_en_nxt     = 2'b00;
              w_hold_cnt_nxt   = '0;
              w_state_nxt      = ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          // Ack wins over a coincident vsync; that vsync is consumed here,
          // so IDLE only re-arms on the following frame.
          if (rd_ack) begin
            w_lp_valid_nxt = 1'b0;
            w_lp_miss_nxt  = 1'b0;
            w_state_nxt    = ST_IDLE;
          end else if (w_vsync_rise) begin
            w_hold_cnt_nxt = w_hold_inc;
            if (w_hold_inc == HW'(HOLD_FRAMES)) begin
              w_lp_valid_nxt = 1'b0;
              w_lp_miss_nxt  = 1'b0;
              w_state_nxt    = ST_IDLE;
            end
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // Request latch: edge-set, cleared when served; auto-fire overrides.
  always_comb begin
    w_req_nxt = (r_req | (w_trig_rise & gun_present)) & ~w_req_clr;
    if (auto_fire) begin
      w_req_nxt = gun_present;
    end
    if (!enable) begin
      w_req_nxt = 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_trig_s1  <= 2'b00;
      r_trig_s2  <= 2'b00;
      r_trig_d   <= 2'b00;
      r_vsync_d  <= 1'b0;
      r_req      <= 2'b00;
      r_last     <= 1'b1;
      r_sel      <= 1'b0;
      r_miss_cnt <= '0;
      r_hold_cnt <= '0;
      r_gun_en   <= 2'b00;
      r_lp_valid <= 1'b0;
      r_lp_miss  <= 1'b0;
      r_lp_port  <= 1'b0;
      r_lp_x     <= '0;
      r_lp_y     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_trig_s1  <= trig;
      r_trig_s2  <= r_trig_s1;
      r_trig_d   <= r_trig_s2;
      r_vsync_d  <= vsync;
      r_req      <= w_req_nxt;
      r_last     <= w_last_nxt;
      r_sel      <= w_sel_nxt;
      r_miss_cnt <= w_miss_cnt_nxt;
      r_hold_cnt <= w_hold_cnt_nxt;
      r_gun_en   <= w_gun_en_nxt;
      r_lp_valid <= w_lp_valid_nxt;
      r_lp_miss  <= w_lp_miss_nxt;
      r_lp_port  <= w_lp_port_nxt;
      r_lp_x     <= w_lp_x_nxt;
      r_lp_y     <= w_lp_y_nxt;
    end
  end

  assign gun_en    = r_gun_en;
  assign lp_valid  = r_lp_valid;
  assign lp_miss   = r_lp_miss;
  assign lp_port   = r_lp_port;
  assign lp_x      = r_lp_x;
  assign lp_y      = r_lp_y;
  assign busy      = (r_state != ST_IDLE);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_jag_lightgun_sched.sv
// ---------------------------------------------------------------------------
// tb_jag_lightgun_sched
//
// Directed bench for jag_lightgun_sched with default parameters
// (MISS_FRAMES=2, HOLD_FRAMES=4). Inputs change and outputs are observed
// on the falling clock edge, so every observation reflects the preceding
// rising edge.
// ---------------------------------------------------------------------------
module tb_jag_lightgun_sched;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        auto_fire;
  logic [1:0]  gun_present;
  logic [1:0]  trig;
  logic [1:0]  hit;
  logic        vsync;
  logic [11:0] cycle;
  logic [9:0]  scanline;
  logic        rd_ack;
  logic [1:0]  gun_en;
  logic        lp_valid;
  logic        lp_miss;
  logic        lp_port;
  logic [11:0] lp_x;
  logic [9:0]  lp_y;
  logic        busy;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  jag_lightgun_sched #(.MISS_FRAMES(2), .HOLD_FRAMES(4)) dut (
    .clk(clk), .reset(reset), .enable(enable), .auto_fire(auto_fire),
    .gun_present(gun_present), .trig(trig), .hit(hit), .vsync(vsync),
    .cycle(cycle), .scanline(scanline), .rd_ack(rd_ack),
    .gun_en(gun_en), .lp_valid(lp_valid), .lp_miss(lp_miss),
    .lp_port(lp_port), .lp_x(lp_x), .lp_y(lp_y), .busy(busy),
    .dbg_state(dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; trig = 2'b00; hit = 2'b00; vsync = 1'b0; rd_ack = 1'b0;
    step(2);
    reset = 1'b0;
    step(1);
  endtask

  task automatic press(input logic [1:0] m);
    trig = m;
    step(4);
    trig = 2'b00;
    step(2);
  endtask

  task automatic vsync_pulse();
    vsync = 1'b1;
    step(1);
    vsync = 1'b0;
    step(1);
  endtask

  task automatic fire_hit(input logic [1:0] m, input logic [11:0] x, input logic [9:0] y);
    hit = m; cycle = x; scanline = y;
    step(1);
    hit = 2'b00;
  endtask

  task automatic ack();
    rd_ack = 1'b1;
    step(1);
    rd_ack = 1'b0;
  endtask

  // Scenarios
  task automatic test_reset();
    enable = 1'b1; auto_fire = 1'b0; gun_present = 2'b11;
    cycle = 12'h000; scanline = 10'd0;
    reset = 1'b1; trig = 2'b00; hit = 2'b00; vsync = 1'b0; rd_ack = 1'b0;
    step(3);
    n_checks++; if (gun_en !== 2'b00) begin n_fail++; $display("FAIL reset_gun_en: got %b want 00", gun_en); end
    n_checks++; if ({lp_valid, lp_miss, lp_port} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b want 000", {lp_valid, lp_miss, lp_port}); end
    n_checks++; if ({lp_x, lp_y} !== 22'd0) begin n_fail++; $display("FAIL reset_xy: got %h want 0", {lp_x, lp_y}); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    reset = 1'b0;
    step(1);
  endtask

  task automatic test_single_hit();
    press(2'b01);
    n_checks++; if (gun_en !== 2'b00) begin n_fail++; $display("FAIL single_pre_arm: got %b want 00", gun_en); end
    vsync_pulse();
    n_checks++; if (gun_en !== 2'b01) begin n_fail++; $display("FAIL single_gun_en: got %b want 01", gun_en); end
    n_checks++; if (dbg_state !== 2'd1) begin n_fail++; $display("FAIL single_state_scan: got %0d want 1", dbg_state); end
    fire_hit(2'b01, 12'h2A0, 10'd100);
    n_checks++; if (lp_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b want 1", lp_valid); end
    n_checks++; if (lp_x !== 12'h2A0) begin n_fail++; $display("FAIL single_x: got %h want 2a0", lp_x); end
    n_checks++; if (lp_y !== 10'd100) begin n_fail++; $display("FAIL single_y: got %0d want 100", lp_y); end
    n_checks++; if ({lp_port, lp_miss} !== 2'b00) begin n_fail++; $display("FAIL single_port_miss: got %b want 00", {lp_port, lp_miss}); end
    n_checks++; if (gun_en !== 2'b00) begin n_fail++; $display("FAIL single_gun_en_drop: got %b want 00", gun_en); end
    ack();
    n_checks++; if (lp_valid !== 1'b0) begin n_fail++; $display("FAIL single_ack_valid: got %b want 0", lp_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_ack_busy: got %b want 0", busy); end
  endtask

  // Runs right after test_single_hit, so lp_x still holds 0x2A0 before the miss.
  task automatic test_miss();
    press(2'b10);
    vsync_pulse();
    n_checks++; if (gun_en !== 2'b10) begin n_fail++; $display("FAIL miss_gun_en: got %b want 10", gun_en); end
    vsync_pulse();
    n_checks++; if ({lp_valid, gun_en} !== 3'b010) begin n_fail++; $display("FAIL miss_first_frame: got %b want 010", {lp_valid, gun_en}); end
    vsync_pulse();
    n_checks++; if ({lp_valid, lp_miss, lp_port} !== 3'b111) begin n_fail++; $display("FAIL miss_result: got %b want 111", {lp_valid, lp_miss, lp_port}); end
    n_checks++; if (lp_x !== 12'h000) begin n_fail++; $display("FAIL miss_x_zero: got %h want 000", lp_x); end
    n_checks++; if (gun_en !== 2'b00) begin n_fail++; $display("FAIL miss_gun_en_drop: got %b want 00", gun_en); end
    ack();
    n_checks++; if ({lp_valid, lp_miss} !== 2'b00) begin n_fail++; $display("FAIL miss_ack: got %b want 00", {lp_valid, lp_miss}); end
  endtask

  task automatic test_alternate();
    do_reset();
    press(2'b11);
    vsync_pulse();
    n_checks++; if (gun_en !== 2'b01) begin n_fail++; $display("FAIL alt_first_arm: got %b want 01", gun_en); end
    fire_hit(2'b11, 12'h100, 10'd10);
    n_checks++; if (lp_port !== 1'b0) begin n_fail++; $display("FAIL alt_first_port: got %b want 0", lp_port); end
    ack();
    // Gun 0 re-requests while gun 1 is still pending; gun 1 must be served.
    press(2'b01);
    vsync_pulse();
    n_checks++; if (gun_en !== 2'b10) begin n_fail++; $display("FAIL alt_second_arm: got %b want 10", gun_en); end
    fire_hit(2'b11, 12'h200, 10'd20);
    n_checks++; if ({lp_valid, lp_port} !== 2'b11) begin n_fail++; $display("FAIL alt_second_port: got %b want 11", {lp_valid, lp_port}); end
    n_checks++; if (lp_x !== 12'h200) begin n_fail++; $display("FAIL alt_second_x: got %h want 200", lp_x); end
    ack();
    vsync_pulse();
    n_checks++; if (gun_en !== 2'b01) begin n_fail++; $display("FAIL alt_third_arm: got %b want 01", gun_en); end
    fire_hit(2'b01, 12'h300, 10'd30);
    n_checks++; if (lp_port !== 1'b0) begin n_fail++; $display("FAIL alt_third_port: got %b want 0", lp_port); end
    ack();
  endtask

  task automatic test_hold();
    do_reset();
    press(2'b01);
    vsync_pulse();
    fire_hit(2'b01, 12'h155, 10'h03F);
    for (int i = 0; i < 3; i++) vsync_pulse();
    n_checks++; if (lp_valid !== 1'b1) begin n_fail++; $display("FAIL hold_three_frames: got %b want 1", lp_valid); end
    vsync_pulse();
    n_checks++; if ({lp_valid, busy} !== 2'b00) begin n_fail++; $display("FAIL hold_drop: got %b want 00", {lp_valid, busy}); end
    n_checks++; if ({lp_x, lp_y} !== {12'h155, 10'h03F}) begin n_fail++; $display("FAIL hold_retain_xy: got %h want %h", {lp_x, lp_y}, {12'h155, 10'h03F}); end

    // Ack coinciding with vsync: ack wins and the pending request waits a frame.
    press(2'b01);
    vsync_pulse();
    fire_hit(2'b01, 12'h0AA, 10'd5);
    press(2'b01);
    rd_ack = 1'b1; vsync = 1'b1;
    step(1);
    rd_ack = 1'b0;
    n_checks++; if ({lp_valid, busy} !== 2'b00) begin n_fail++; $display("FAIL ackvs_released: got %b want 00", {lp_valid, busy}); end
    step(2);
    vsync = 1'b0;
    step(1);
    n_checks++; if (gun_en !== 2'b00) begin n_fail++; $display("FAIL ackvs_no_rearm: got %b want 00", gun_en); end
    vsync_pulse();
    n_checks++; if (gun_en !== 2'b01) begin n_fail++; $display("FAIL ackvs_next_frame: got %b want 01", gun_en); end
    fire_hit(2'b01, 12'h011, 10'd1);
    ack();
  endtask

  task automatic test_edge_cases();
    do_reset();
    // Hit coinciding with the frame that would otherwise complete a miss.
    press(2'b01);
    vsync_pulse();
    vsync_pulse();
    hit = 2'b01; vsync = 1'b1; cycle = 12'h0F0; scanline = 10'd77;
    step(1);
    hit = 2'b00; vsync = 1'b0;
    n_checks++; if ({lp_valid, lp_miss} !== 2'b10) begin n_fail++; $display("FAIL edge_hit_vs_miss: got %b want 10", {lp_valid, lp_miss}); end
    n_checks++; if (lp_x !== 12'h0F0) begin n_fail++; $display("FAIL edge_hit_x: got %h want 0f0", lp_x); end
    step(1);
    ack();

    // Hit on the non-selected gun is ignored.
    press(2'b01);
    vsync_pulse();
    fire_hit(2'b10, 12'h123, 10'd9);
    n_checks++; if ({lp_valid, gun_en} !== 3'b001) begin n_fail++; $display("FAIL edge_other_hit: got %b want 001", {lp_valid, gun_en}); end

    // Enable dropped mid-scan.
    enable = 1'b0;
    step(1);
    n_checks++; if ({gun_en, busy} !== 3'b000) begin n_fail++; $display("FAIL edge_disable: got %b want 000", {gun_en, busy}); end
    enable = 1'b1;
    vsync_pulse();
    n_checks++; if (gun_en !== 2'b00) begin n_fail++; $display("FAIL edge_disable_req_cleared: got %b want 00", gun_en); end

    // Armed gun removed mid-scan.
    press(2'b01);
    vsync_pulse();
    gun_present = 2'b10;
    step(1);
    n_checks++; if ({busy, gun_en, lp_valid} !== 4'b0000) begin n_fail++; $display("FAIL edge_unplug: got %b want 0000", {busy, gun_en, lp_valid}); end
    gun_present = 2'b11;

    // Reset pulse while holding a result.
    press(2'b01);
    vsync_pulse();
    fire_hit(2'b01, 12'h3FF, 10'd511);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    n_checks++; if ({gun_en, lp_valid, lp_miss, lp_port, lp_x, lp_y, busy} !== 28'd0) begin n_fail++; $display("FAIL edge_reset_hold: got %h want 0", {gun_en, lp_valid, lp_miss, lp_port, lp_x, lp_y, busy}); end
    step(1);
  endtask

  task automatic test_auto_fire();
    do_reset();
    auto_fire = 1'b1;
    gun_present = 2'b11;
    step(2);
    for (int k = 0; k < 4; k++) begin
      trig = 2'($urandom_range(0, 3));
      vsync_pulse();
      trig = 2'($urandom_range(0, 3));
      n_checks++; if (gun_en !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin n_fail++; $display("FAIL auto_arm_%0d: got %b", k, gun_en); end
      fire_hit(2'b11, 12'(k + 1), 10'(k));
      n_checks++; if ({lp_valid, lp_port} !== {1'b1, 1'(k % 2)}) begin n_fail++; $display("FAIL auto_port_%0d: got %b want %b", k, {lp_valid, lp_port}, {1'b1, 1'(k % 2)}); end
      ack();
    end
    trig = 2'b00;
    auto_fire = 1'b0;
  endtask

  // Sequence and report
  initial begin
    test_reset();
    test_single_hit();
    test_miss();
    test_alternate();
    test_hold();
    test_edge_cases();
    test_auto_fire();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
